// File: rtl/bf2_dif_stream.sv
// Streaming radix-2 DIF butterfly for one FFT stage: A = a+b, B = (a-b)*W^k,
// three register stages with valid/ready backpressure and an elaborated twiddle ROM.
module bf2_dif_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16,
  parameter int POW        = 4,
  parameter int SERIES     = 0,
  parameter int SCALE      = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sop,
  input  logic signed [DATA_WIDTH-1:0]      in_a_r,
  input  logic signed [DATA_WIDTH-1:0]      in_a_i,
  input  logic signed [DATA_WIDTH-1:0]      in_b_r,
  input  logic signed [DATA_WIDTH-1:0]      in_b_i,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_sop,
  output logic signed [DATA_WIDTH-SCALE:0]  out_a_r,
  output logic signed [DATA_WIDTH-SCALE:0]  out_a_i,
  output logic signed [DATA_WIDTH-SCALE:0]  out_b_r,
  output logic signed [DATA_WIDTH-SCALE:0]  out_b_i,
  output logic [POW-2:0]                    out_k
);
  localparam int TW_FRAC = TW_WIDTH - 2;
  localparam int N       = 1 << POW;
  localparam int HALF    = N / 2;
  localparam int SW      = DATA_WIDTH + 1;
  localparam int PW      = SW + TW_WIDTH;
  localparam int XW      = PW + 2;
  localparam int OW      = DATA_WIDTH + 1 - SCALE;
  localparam int RSH     = TW_FRAC + SCALE;
  localparam int JW      = POW - SERIES - 1;
  localparam int JWE     = (JW < 1) ? 1 : JW;
  localparam int KW      = POW - 1;
  localparam logic signed [XW-1:0] SAT_MAX = XW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] SAT_MIN = XW'(-(64'sd1 <<< (OW - 1)));

  function automatic int tw_round(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic signed [XW-1:0] round_shift(input logic signed [XW-1:0] x);
    logic signed [XW-1:0] bias;
    bias = '0;
    bias[RSH-1] = 1'b1;
    return (x + bias) >>> RSH;
  endfunction

  function automatic logic signed [XW-1:0] scale_sum(input logic signed [SW-1:0] s);
    logic signed [XW-1:0] x;
    x = XW'(s);
    return (SCALE != 0) ? ((x + XW'(1)) >>> 1) : x;
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [XW-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[OW-1:0];
    if (x < SAT_MIN) return SAT_MIN[OW-1:0];
    return x[OW-1:0];
  endfunction

  // Twiddle ROM: W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), 1.0 = 2^TW_FRAC
  logic signed [TW_WIDTH-1:0] rom_r [HALF];
  logic signed [TW_WIDTH-1:0] rom_i [HALF];
  for (genvar g = 0; g < HALF; g++) begin : g_rom
    localparam real ANG = 2.0 * 3.14159265358979323846 * real'(g) / real'(N);
    localparam int  WR  = tw_round($cos(ANG) * real'(1 << TW_FRAC));
    localparam int  WI  = tw_round(-$sin(ANG) * real'(1 << TW_FRAC));
    assign rom_r[g] = TW_WIDTH'(WR);
    assign rom_i[g] = TW_WIDTH'(WI);
  end

  logic           adv, acc;
  logic [JWE-1:0] j_cnt, j_used;
  logic [KW-1:0]  k_sel;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign acc      = in_valid && adv;

  // An sop pair always restarts the group at j = 0
  always_comb begin
    j_used = (in_sop || JW == 0) ? '0 : j_cnt;
    k_sel  = KW'(j_used) << SERIES;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   j_cnt <= '0;
    else if (acc) j_cnt <= (JW == 0) ? '0 : j_used + 1'b1;
  end

  logic                       vld_p0, sop_p0;
  logic [KW-1:0]              k_p0;
  logic signed [SW-1:0]       s_r_p0, s_i_p0, d_r_p0, d_i_p0;
  logic signed [TW_WIDTH-1:0] w_r_p0, w_i_p0;

  // Stage 1: sum/difference with full growth, twiddle fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;  sop_p0 <= 1'b0;  k_p0 <= '0;
      s_r_p0 <= '0;    s_i_p0 <= '0;    d_r_p0 <= '0;  d_i_p0 <= '0;
      w_r_p0 <= '0;    w_i_p0 <= '0;
    end else if (adv) begin
      vld_p0 <= acc;
      sop_p0 <= acc && in_sop;
      k_p0   <= k_sel;
      s_r_p0 <= SW'(in_a_r) + SW'(in_b_r);
      s_i_p0 <= SW'(in_a_i) + SW'(in_b_i);
      d_r_p0 <= SW'(in_a_r) - SW'(in_b_r);
      d_i_p0 <= SW'(in_a_i) - SW'(in_b_i);
      w_r_p0 <= rom_r[k_sel];
      w_i_p0 <= rom_i[k_sel];
    end
  end

  logic                 vld_p1, sop_p1;
  logic [KW-1:0]        k_p1;
  logic signed [SW-1:0] s_r_p1, s_i_p1;
  logic signed [PW-1:0] pr1_p1, pr2_p1, pi1_p1, pi2_p1;

  // Stage 2: four full-precision partial products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;  sop_p1 <= 1'b0;  k_p1 <= '0;
      s_r_p1 <= '0;    s_i_p1 <= '0;
      pr1_p1 <= '0;    pr2_p1 <= '0;    pi1_p1 <= '0;  pi2_p1 <= '0;
    end else if (adv) begin
      vld_p1 <= vld_p0;
      sop_p1 <= sop_p0;
      k_p1   <= k_p0;
      s_r_p1 <= s_r_p0;
      s_i_p1 <= s_i_p0;
      pr1_p1 <= PW'(d_r_p0) * PW'(w_r_p0);
      pr2_p1 <= PW'(d_i_p0) * PW'(w_i_p0);
      pi1_p1 <= PW'(d_r_p0) * PW'(w_i_p0);
      pi2_p1 <= PW'(d_i_p0) * PW'(w_r_p0);
    end
  end

  logic signed [XW-1:0] re_p1, im_p1;
  assign re_p1 = XW'(pr1_p1) - XW'(pr2_p1);
  assign im_p1 = XW'(pi1_p1) + XW'(pi2_p1);

  // Stage 3: combine, round, saturate into the output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;  out_sop <= 1'b0;  out_k <= '0;
      out_a_r   <= '0;    out_a_i <= '0;    out_b_r <= '0;  out_b_i <= '0;
    end else if (adv) begin
      out_valid <= vld_p1;
      out_sop   <= sop_p1;
      out_k     <= k_p1;
      out_a_r   <= saturate(scale_sum(s_r_p1));
      out_a_i   <= saturate(scale_sum(s_i_p1));
      out_b_r   <= saturate(round_shift(re_p1));
      out_b_i   <= saturate(round_shift(im_p1));
    end
  end
endmodule

// File: tb/tb_bf2_dif_stream.sv
// Bench for bf2_dif_stream: five stage/scale configurations share one input stream;
// each is scored against a plain-arithmetic FFT butterfly model.
module tb_bf2_dif_stream;
  localparam int NI = 5;

  function automatic int ser_of(input int g);
    return (g < 2) ? 0 : g - 1;
  endfunction
  function automatic int scl_of(input int g);
    return (g == 1 || g == 3) ? 1 : 0;
  endfunction

  typedef struct {
    longint ar, ai, br, bi;
    int     k;
    bit     sop;
  } rec_t;

  typedef struct {
    int ar, ai, br, bi;
    bit sop;
    int ea_r, ea_i, eb_r, eb_i, ek;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_sop, out_ready;
  logic signed [15:0] in_a_r, in_a_i, in_b_r, in_b_i;
  logic o_rdy [NI];
  logic o_vld [NI];
  logic o_sop [NI];
  logic [2:0] o_k [NI];
  logic signed [31:0] o_ar [NI];
  logic signed [31:0] o_ai [NI];
  logic signed [31:0] o_br [NI];
  logic signed [31:0] o_bi [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = ser_of(g);
    localparam int C = scl_of(g);
    logic signed [16-C:0] a_r, a_i, b_r, b_i;
    bf2_dif_stream #(.DATA_WIDTH(16), .TW_WIDTH(16), .POW(4), .SERIES(S), .SCALE(C)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(o_rdy[g]), .in_sop(in_sop),
      .in_a_r(in_a_r), .in_a_i(in_a_i), .in_b_r(in_b_r), .in_b_i(in_b_i),
      .out_valid(o_vld[g]), .out_ready(out_ready), .out_sop(o_sop[g]),
      .out_a_r(a_r), .out_a_i(a_i), .out_b_r(b_r), .out_b_i(b_i),
      .out_k(o_k[g])
    );
    assign o_ar[g] = 32'(a_r);
    assign o_ai[g] = 32'(a_i);
    assign o_br[g] = 32'(b_r);
    assign o_bi[g] = 32'(b_i);
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  rec_t exp_q [NI][$];
  rec_t cap0[$];
  rec_t cap1[$];
  int   jm [NI];
  bit   stall [NI];
  rec_t held [NI];
  bit   acc;
  vec_t tbl [9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_rec(input string name, input rec_t a, input rec_t e);
    chk({name, ".a_r"}, a.ar, e.ar);
    chk({name, ".a_i"}, a.ai, e.ai);
    chk({name, ".b_r"}, a.br, e.br);
    chk({name, ".b_i"}, a.bi, e.bi);
    chk({name, ".k"},   a.k,  e.k);
    chk({name, ".sop"}, a.sop, e.sop);
  endtask

  function automatic longint sat_to(input longint x, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic longint tw(input int k, input bit imag);
    real ang, v;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / 16.0;
    v = imag ? -$sin(ang) : $cos(ang);
    return longint'($rtoi($floor(v * 16384.0 + 0.5)));
  endfunction

  // Reference butterfly on complex integers for N = 16
  function automatic rec_t model(input longint ar, ai, br, bi, input int j, input int ser,
                                 input int scl, input bit sop);
    rec_t   e;
    longint wr, wi, sr, si, dr, di, re, im;
    int     r, ow;
    e.k = j * (1 << ser);
    wr = tw(e.k, 1'b0);
    wi = tw(e.k, 1'b1);
    sr = ar + br;  si = ai + bi;
    dr = ar - br;  di = ai - bi;
    re = dr * wr - di * wi;
    im = dr * wi + di * wr;
    r  = 14 + scl;
    ow = 17 - scl;
    e.br = sat_to((re + (64'sd1 <<< (r - 1))) >>> r, ow);
    e.bi = sat_to((im + (64'sd1 <<< (r - 1))) >>> r, ow);
    e.ar = sat_to((scl != 0) ? ((sr + 1) >>> 1) : sr, ow);
    e.ai = sat_to((scl != 0) ? ((si + 1) >>> 1) : si, ow);
    e.sop = sop;
    return e;
  endfunction

  function automatic rec_t get(input int i);
    rec_t r;
    r.ar = o_ar[i];  r.ai = o_ai[i];
    r.br = o_br[i];  r.bi = o_bi[i];
    r.k  = int'(o_k[i]);
    r.sop = o_sop[i];
    return r;
  endfunction

  task automatic mon();
    rec_t got, e;
    int   ju;
    acc = in_valid && o_rdy[0];
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        exp_q[i].delete();
        jm[i] = 0;
        stall[i] = 1'b0;
      end
      return;
    end
    for (int i = 0; i < NI; i++) begin
      got = get(i);
      if (stall[i]) chk_rec($sformatf("stall_hold%0d", i), got, held[i]);
      if (o_vld[i] && out_ready) begin
        if (i == 0) cap0.push_back(got);
        if (i == 1) cap1.push_back(got);
        chk($sformatf("sb%0d_has_expected", i), exp_q[i].size() > 0, 1);
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          chk_rec($sformatf("sb%0d", i), got, e);
        end
      end
      stall[i] = o_vld[i] && !out_ready;
      held[i]  = got;
      if (in_valid && o_rdy[i]) begin
        ju = in_sop ? 0 : jm[i];
        jm[i] = (ju + 1) % (8 >> ser_of(i));
        exp_q[i].push_back(model(in_a_r, in_a_i, in_b_r, in_b_i, ju, ser_of(i), scl_of(i), in_sop));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint ar, ai, br, bi, input bit sop);
    in_valid = 1'b1;  in_sop = sop;
    in_a_r = 16'(ar); in_a_i = 16'(ai); in_b_r = 16'(br); in_b_i = 16'(bi);
    for (int t = 0; t < 200; t++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;  in_sop = 1'b0;  out_ready = 1'b1;
    repeat (n) step();
  endtask

  function automatic logic signed [15:0] rnd_sample();
    if ($urandom_range(7) == 0) return ($urandom_range(1) == 1) ? 16'sd32767 : -16'sd32768;
    return 16'($urandom);
  endfunction

  initial begin
    int ks [12];
    int base, idx, nacc;
    tbl[0] = '{1000, 0, 0, 0, 1'b1, 1000, 0, 1000, 0, 0};
    tbl[1] = '{1000, 0, 0, 0, 1'b0, 1000, 0, 924, -383, 1};
    tbl[2] = '{1000, 0, 0, 0, 1'b0, 1000, 0, 707, -707, 2};
    tbl[3] = '{1000, 0, 0, 0, 1'b0, 1000, 0, 383, -924, 3};
    tbl[4] = '{1000, 0, 0, 0, 1'b0, 1000, 0, 0, -1000, 4};
    tbl[5] = '{1000, 0, 0, 0, 1'b0, 1000, 0, -383, -924, 5};
    tbl[6] = '{1000, 0, 0, 0, 1'b0, 1000, 0, -707, -707, 6};
    tbl[7] = '{1000, 0, 0, 0, 1'b0, 1000, 0, -924, -383, 7};
    tbl[8] = '{32767, 32767, -32768, -32768, 1'b1, -1, -1, 65535, 65535, 0};
    ks = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7, 0};

    // Reset with a valid input pending
    rst_n = 1'b0;  in_valid = 1'b1;  in_sop = 1'b1;  out_ready = 1'b1;
    in_a_r = 16'sd5;  in_a_i = 16'sd6;  in_b_r = 16'sd7;  in_b_i = 16'sd8;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("reset_out_valid%0d", i), o_vld[i], 0);
        chk($sformatf("reset_in_ready%0d", i), o_rdy[i], 1);
      end
      chk("reset_out_k", o_k[0], 0);
      chk("reset_out_b_r", o_br[0], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    in_valid = 1'b0;  in_sop = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("latency_c%0d", c), o_vld[0], c == 3);
      mon();
      @(posedge clk);
      #1;
    end
    idle(4);

    // Table: constant input over a full SERIES=0 group, then a saturation pair
    cap0.delete();  cap1.delete();
    for (int i = 0; i < 9; i++) send(tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, tbl[i].sop);
    idle(6);
    chk("table_count", cap0.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < cap0.size()) begin
        chk($sformatf("tbl%0d.a_r", i), cap0[i].ar, tbl[i].ea_r);
        chk($sformatf("tbl%0d.a_i", i), cap0[i].ai, tbl[i].ea_i);
        chk($sformatf("tbl%0d.b_r", i), cap0[i].br, tbl[i].eb_r);
        chk($sformatf("tbl%0d.b_i", i), cap0[i].bi, tbl[i].eb_i);
        chk($sformatf("tbl%0d.k", i),   cap0[i].k,  tbl[i].ek);
      end
    end
    chk("sat_count", cap1.size(), 9);
    if (cap1.size() == 9) begin
      chk("sat.a_r", cap1[8].ar, 0);
      chk("sat.a_i", cap1[8].ai, 0);
      chk("sat.b_r", cap1[8].br, 32767);
      chk("sat.b_i", cap1[8].bi, 32767);
    end

    // sop resynchronisation mid-group, then the wrap after j = 7
    cap0.delete();
    for (int i = 0; i < 12; i++) send(i * 10, -i, 3, 7, (i == 0 || i == 3));
    idle(6);
    chk("resync_count", cap0.size(), 12);
    for (int i = 0; i < 12 && i < cap0.size(); i++) chk($sformatf("resync_k%0d", i), cap0[i].k, ks[i]);

    // Backpressure: ready toggles, then held low for five cycles
    base = cap0.size();
    idx = 0;
    for (int c = 0; c < 40 && (idx < 8 || c < 13); c++) begin
      out_ready = (c < 8) ? (c % 2 == 0) : (c >= 13);
      in_valid = (idx < 8);
      in_sop = (idx == 0);
      in_a_r = 16'(100 * idx);  in_a_i = 16'(-50 * idx);
      in_b_r = 16'(7 * idx);    in_b_i = 16'(idx);
      step();
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 8);
    idle(8);
    chk("bp_count", cap0.size() - base, 8);

    // Asynchronous reset with pairs in flight
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(i + 1, i + 2, i + 3, i + 4, i == 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", o_vld[0], 0);
    chk("midrst_in_ready", o_rdy[0], 1);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cap0.delete();
    for (int i = 0; i < 3; i++) send(200 + i, 0, 0, 0, 1'b0);
    idle(6);
    chk("midrst_count", cap0.size(), 3);
    for (int i = 0; i < 3 && i < cap0.size(); i++) chk($sformatf("midrst_k%0d", i), cap0[i].k, i);

    // Random traffic against the model
    nacc = 0;
    for (int c = 0; c < 60000 && nacc < 10000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_sop    = ($urandom_range(11) == 0);
      in_a_r = rnd_sample();  in_a_i = rnd_sample();
      in_b_r = rnd_sample();  in_b_i = rnd_sample();
      step();
      if (acc) nacc++;
    end
    chk("random_pairs", nacc >= 10000, 1);
    idle(10);
    for (int i = 0; i < NI; i++) chk($sformatf("drained%0d", i), exp_q[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
